// File: rtl/regfile_pkg.sv
// Shared definitions for the 16 x 32-bit register file and its access sequencer.
package regfile_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned LEN_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

endpackage

// File: rtl/regfile_access_ctrl.sv
// Burst access sequencer in front of the register file: accepts read/write
// burst commands, streams write beats into the file and read beats out
// through a one-deep registered response stage.
module regfile_access_ctrl
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_last,
    output logic              rf_write_en,
    output logic              rf_read_en,
    output logic [ADDR_W-1:0] rf_write_line,
    output logic [ADDR_W-1:0] rf_read_line,
    output logic [DATA_W-1:0] rf_data_in,
    input  logic [DATA_W-1:0] rf_data_out,
    output logic              busy
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [LEN_W-1:0]  beat_cnt;
    logic              cmd_fire;
    logic              write_fire;
    logic              read_fire;
    logic              beat_fire;
    logic              last_beat;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake decode, next state and register-file strobes.
    always_comb begin
        state_nxt     = state;
        cmd_ready     = 1'b0;
        wdata_ready   = 1'b0;
        cmd_fire      = 1'b0;
        write_fire    = 1'b0;
        read_fire     = 1'b0;
        rf_write_en   = 1'b0;
        rf_read_en    = 1'b0;
        rf_write_line = addr_cnt;
        rf_read_line  = addr_cnt;
        rf_data_in    = wdata;
        last_beat     = (beat_cnt == '0);

        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cmd_fire  = 1'b1;
                    state_nxt = cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                wdata_ready = 1'b1;
                write_fire  = wdata_valid;
                rf_write_en = write_fire;
                if (write_fire && last_beat) begin
                    state_nxt = IDLE;
                end
            end
            READ: begin
                // A beat may issue whenever the response slot is empty or
                // is being drained in this same cycle.
                read_fire  = !rdata_valid || rdata_ready;
                rf_read_en = read_fire;
                if (read_fire && last_beat) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        beat_fire = write_fire || read_fire;
    end

    // Burst address and remaining-beat counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_cnt <= '0;
            beat_cnt <= '0;
        end else if (cmd_fire) begin
            addr_cnt <= cmd_addr;
            beat_cnt <= cmd_len;
        end else if (beat_fire) begin
            addr_cnt <= addr_cnt + ADDR_W'(1);
            beat_cnt <= beat_cnt - LEN_W'(1);
        end
    end

    // Registered read response slot; holds while stalled by rdata_ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_valid <= 1'b0;
            rdata       <= '0;
            rdata_last  <= 1'b0;
        end else if (read_fire) begin
            rdata_valid <= 1'b1;
            rdata       <= rf_data_out;
            rdata_last  <= last_beat;
        end else if (rdata_valid && rdata_ready) begin
            rdata_valid <= 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/regfile_access_ctrl.md
# regfile_access_ctrl

Burst access sequencer sitting directly upstream of the 16 x 32-bit register file. It accepts read/write burst commands over a valid/ready channel and streams write data in and read data out with valid/ready handshakes. It drives the register file's write_en/write_line/data_in and read_en/read_line ports, and captures its combinational data_out into a registered response stage.

## Interface
- DATA_W, 32, data word width
- ADDR_W, 4, line index width (16 lines)
- LEN_W, 4, burst length field width (beats minus one, 1..16 beats)

Ports:
- clk  in  1  clock, all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  first line of burst
- cmd_len  in  LEN_W  beats minus one
- wdata_valid  in  1  write beat offered
- wdata_ready  out  1  write beat accepted
- wdata  in  DATA_W  write beat data
- rdata_valid  out  1  read beat available
- rdata_ready  in  1  read beat consumed
- rdata  out  DATA_W  read beat data
- rdata_last  out  1  final beat of read burst
- rf_write_en, rf_read_en  out  1  register file enables
- rf_write_line, rf_read_line  out  ADDR_W  register file line selects
- rf_data_in  out  DATA_W  register file write data
- rf_data_out  in  DATA_W  register file combinational read data
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, WRITE, READ.
- IDLE: cmd_ready = 1. On cmd_valid: latch cmd_addr into addr_cnt and cmd_len into beat_cnt, go to WRITE (cmd_write = 1) or READ.
- WRITE: wdata_ready = 1. A write beat fires when wdata_valid is high. In that cycle: rf_write_en = 1, rf_write_line = addr_cnt, rf_data_in = wdata.
- READ: a read beat fires when rdata_valid = 0 or rdata_ready = 1. In that cycle: rf_read_en = 1, rf_read_line = addr_cnt. At the edge: rdata <= rf_data_out, rdata_valid <= 1, rdata_last <= (beat_cnt == 0).
- Per beat: addr_cnt increments modulo 16 (15 -> 0 wrap); beat_cnt decrements.
- End of burst: the beat with beat_cnt == 0 returns the FSM to IDLE.
- Response stage: rdata_valid clears on rdata_valid & rdata_ready when no new beat loads. rdata/rdata_last hold stable while rdata_valid & !rdata_ready.
- A pending final read beat may remain in the response stage while a new command is accepted in IDLE.
- Enables are low outside a firing beat. Line/data outputs are don't-care while their enable is low.
- Reset values: state IDLE, rdata_valid 0, rdata 0, rdata_last 0, busy 0, rf enables 0, cmd_ready 1. Upstream must not assert cmd_valid during reset.
- Reset mid-burst: the burst is abandoned and the pending response is dropped. Lines already written keep their data (register file has its own reset).

## Timing
- Write beat commits to the register file at the same edge as the handshake.
- Read latency: 1 cycle from read beat firing to rdata_valid.
- Throughput: 1 beat/cycle in both directions when unstalled.
- The cycle after a burst's last beat is IDLE. A command offered then is accepted, giving 1 bubble between bursts.
- Read-after-write: a read issued the cycle after a write edge returns the new data.
- Simultaneous cmd_valid during the last beat: not accepted until the following IDLE cycle.

## Structure
- Shared package regfile_pkg: DATA_W, ADDR_W, LEN_W constants and the state enum (IDLE, WRITE, READ). The register file uses the same package.
- Single module. No sub-module; the response register stays inline.

## Test plan
- Write burst addr 2, len 3, data A0..A3 -> lines 2..5 written on four consecutive edges. Read burst addr 2, len 3 -> rdata A0..A3, rdata_last on 4th beat only.
- Wrap: write addr 14, len 3 -> lines 14, 15, 0, 1. Read back in the same order.
- Backpressure: read len 7 with rdata_ready toggling 1010... -> no lost or duplicated beats; rdata stable while stalled; rf_read_en only when the response slot frees.
- Write stall: wdata_valid gaps during a 4-beat write -> rf_write_en high only on valid cycles; addr_cnt advances only on beats.
- Back-to-back: write len 0 to line 7 (value 0xDEADBEEF) then immediate read of line 7 -> 0xDEADBEEF; cmd_ready low exactly one cycle per single-beat command.
- Reset asserted mid read burst -> rdata_valid 0, busy 0, cmd_ready 1 immediately. A new command after deassertion works normally.
